// File: rtl/paula_audio_i2s_tx.sv
// Paula audio I2S transmitter: 64-bit Philips frames, 16-bit words.
// Both mixer sums are captured together once per frame.
module paula_audio_i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] ldatasum,
  input  logic [14:0] rdatasum,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        frame_strobe
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [15:0]   shadow_l;
  logic [15:0]   shadow_r;
  logic [15:0]   word;
  logic [4:0]    k;
  logic [3:0]    idx;
  logic          div_wrap;
  logic          fall;
  logic          frame_wrap;
  logic          sdata_nxt;

  always_comb begin
    div_wrap   = (div_cnt == DIV_LAST);
    fall       = div_wrap & i2s_bclk;
    bit_nxt    = bit_cnt + 6'd1;
    frame_wrap = fall & (bit_cnt == 6'd63);
    k          = bit_nxt[4:0];
    idx        = 4'(5'd16 - k);
    word       = bit_nxt[5] ? shadow_r : shadow_l;
  end

  // slot bit 0 is the I2S one-bit delay, 17..31 are padding
  always_comb begin
    sdata_nxt = 1'b0;
    unique case (1'b1)
      (k >= 5'd1 && k <= 5'd16): sdata_nxt = word[idx];
      default:                   sdata_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      bit_cnt      <= 6'd63;
      i2s_bclk     <= 1'b0;
      i2s_lrck     <= 1'b1;
      i2s_sdata    <= 1'b0;
      frame_strobe <= 1'b0;
      shadow_l     <= '0;
      shadow_r     <= '0;
    end else begin
      frame_strobe <= frame_wrap;
      div_cnt      <= div_wrap ? '0 : DW'(div_cnt + 1'b1);
      if (div_wrap)
        i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrck  <= bit_nxt[5];
        i2s_sdata <= sdata_nxt;
      end
      if (frame_wrap) begin
        shadow_l <= mute ? 16'h0000 : {ldatasum, 1'b0};
        shadow_r <= mute ? 16'h0000 : {rdatasum, 1'b0};
      end
    end
  end

endmodule
